control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Control sequencer: fetch/decode/execute step generator for a single-bus CPU.
// Outputs are decoded combinationally from the current step and the IR opcode.
module control_sequencer (
  input  logic        clk,
  input  logic        in_reset,
  input  logic [31:0] in_ir,
  output logic [9:0]  out_read,
  output logic [9:0]  out_write,
  output logic [3:0]  out_alu_opcode,
  output logic        out_reg_clear,
  output logic        out_mdr_select,
  output logic        out_inc_pc,
  output logic        out_gra,
  output logic        out_grb,
  output logic        out_grc,
  output logic        out_ba_write,
  output logic        out_halted
);

  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 4;

  // Bus-drive strobe bit positions (bit 9 is the memory read access, not a bus driver)
  localparam int unsigned R_REGFILE = 0;
  localparam int unsigned R_HI      = 1;
  localparam int unsigned R_LO      = 2;
  localparam int unsigned R_Z_HI    = 3;
  localparam int unsigned R_Z_LO    = 4;
  localparam int unsigned R_PC      = 5;
  localparam int unsigned R_MDR     = 6;
  localparam int unsigned R_INPORT  = 7;
  localparam int unsigned R_C       = 8;
  localparam int unsigned R_MEM     = 9;

  // Load strobe bit positions
  localparam int unsigned W_REGFILE = 0;
  localparam int unsigned W_HI      = 1;
  localparam int unsigned W_LO      = 2;
  localparam int unsigned W_Z       = 3;
  localparam int unsigned W_PC      = 4;
  localparam int unsigned W_MDR     = 5;
  localparam int unsigned W_IR      = 6;
  localparam int unsigned W_Y       = 7;
  localparam int unsigned W_MAR     = 8;
  localparam int unsigned W_MEM     = 9;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OPC_W-1:0] OP_IN   = 5'd21;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'd23;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'd24;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t state;
  state_t next_state;
  state_t cur;
  logic [OPC_W-1:0] opc;
  logic unused_ir_bits;

  assign opc = in_ir[31:27];
  assign unused_ir_bits = ^in_ir[26:0];

  // Reset overrides the decoded step so no write strobe can glitch out mid-instruction
  assign cur = in_reset ? RST : state;

  // State register
  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) state <= RST;
    else          state <= next_state;
  end

  // Next-step and strobe decode
  always_comb begin
    next_state     = cur;
    out_read       = '0;
    out_write      = '0;
    out_alu_opcode = '0;
    out_reg_clear  = 1'b0;
    out_mdr_select = 1'b0;
    out_inc_pc     = 1'b0;
    out_gra        = 1'b0;
    out_grb        = 1'b0;
    out_grc        = 1'b0;
    out_ba_write   = 1'b0;
    out_halted     = 1'b0;
    case (cur)
      RST: begin
        out_reg_clear = 1'b1;
        next_state    = T0;
      end
      T0: begin
        out_read[R_PC]   = 1'b1;
        out_read[R_MEM]  = 1'b1;
        out_write[W_MAR] = 1'b1;
        out_write[W_PC]  = 1'b1;
        out_inc_pc       = 1'b1;
        next_state       = T1;
      end
      T1: begin
        out_mdr_select   = 1'b1;
        out_write[W_MDR] = 1'b1;
        next_state       = T2;
      end
      T2: begin
        out_read[R_MDR] = 1'b1;
        out_write[W_IR] = 1'b1;
        next_state      = T3;
      end
      T3, T4, T5, T6, T7: begin
        next_state = T0;
        case (opc) inside
          // Register-register ALU ops: Y <- Rb, Z <- Y op Rc, Ra <- Z
          [5'd3:5'd10]: begin
            case (cur)
              T3: begin
                out_grb = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Y] = 1'b1;
                next_state = T4;
              end
              T4: begin
                out_grc = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Z] = 1'b1;
                out_alu_opcode = ALU_W'(opc - 5'd3);
                next_state = T5;
              end
              T5: begin
                out_read[R_Z_LO] = 1'b1; out_gra = 1'b1; out_write[W_REGFILE] = 1'b1;
              end
              default: ;
            endcase
          end
          // Multiply/divide: result split across LO and HI
          [5'd14:5'd15]: begin
            case (cur)
              T3: begin
                out_grb = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Y] = 1'b1;
                next_state = T4;
              end
              T4: begin
                out_grc = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Z] = 1'b1;
                out_alu_opcode = ALU_W'(opc - 5'd6);
                next_state = T5;
              end
              T5: begin
                out_read[R_Z_LO] = 1'b1; out_write[W_LO] = 1'b1;
                next_state = T6;
              end
              T6: begin
                out_read[R_Z_HI] = 1'b1; out_write[W_HI] = 1'b1;
              end
              default: ;
            endcase
          end
          // Unary neg/not
          [5'd16:5'd17]: begin
            case (cur)
              T3: begin
                out_grb = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Z] = 1'b1;
                out_alu_opcode = ALU_W'(opc - 5'd6);
                next_state = T4;
              end
              T4: begin
                out_read[R_Z_LO] = 1'b1; out_gra = 1'b1; out_write[W_REGFILE] = 1'b1;
              end
              default: ;
            endcase
          end
          // Immediate forms and load/store share the effective-address/immediate front half
          OP_LD, OP_LDI, OP_ST, [5'd11:5'd13]: begin
            case (cur)
              T3: begin
                out_grb = 1'b1; out_read[R_REGFILE] = 1'b1; out_write[W_Y] = 1'b1;
                out_ba_write = (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
                next_state = T4;
              end
              T4: begin
                out_read[R_C] = 1'b1; out_write[W_Z] = 1'b1;
                out_alu_opcode = (opc == OP_ANDI) ? ALU_AND :
                                 (opc == OP_ORI)  ? ALU_OR  : ALU_ADD;
                next_state = T5;
              end
              T5: begin
                out_read[R_Z_LO] = 1'b1;
                if (opc == OP_LD || opc == OP_ST) begin
                  out_write[W_MAR] = 1'b1;
                  out_read[R_MEM]  = (opc == OP_LD);
                  next_state       = T6;
                end else begin
                  out_gra = 1'b1; out_write[W_REGFILE] = 1'b1;
                end
              end
              T6: begin
                out_write[W_MDR] = 1'b1;
                if (opc == OP_LD) begin
                  out_mdr_select = 1'b1;
                end else begin
                  out_gra = 1'b1; out_read[R_REGFILE] = 1'b1;
                end
                next_state = T7;
              end
              T7: begin
                if (opc == OP_LD) begin
                  out_read[R_MDR] = 1'b1; out_gra = 1'b1; out_write[W_REGFILE] = 1'b1;
                end else begin
                  out_write[W_MEM] = 1'b1;
                end
              end
              default: ;
            endcase
          end
          // Moves from HI/LO/input port into Ra
          OP_MFHI, OP_MFLO, OP_IN: begin
            if (cur == T3) begin
              out_read[R_HI]     = (opc == OP_MFHI);
              out_read[R_LO]     = (opc == OP_MFLO);
              out_read[R_INPORT] = (opc == OP_IN);
              out_gra = 1'b1; out_write[W_REGFILE] = 1'b1;
            end
          end
          OP_HALT: begin
            if (cur == T3) next_state = HALT;
          end
          default: ;
        endcase
      end
      HALT: begin
        out_halted = 1'b1;
        next_state = HALT;
      end
      default: next_state = RST;
    endcase
  end

endmodule
